// File: rtl/nibble_parity_rx.sv
// Serial nibble receiver feeding the 4-input XOR parity stage.
// Frame format: start bit, 4 data bits LSB first, even-parity bit, stop bit.
// The received nibble and its parity/framing status are held in a one-entry
// buffer with a valid/ready handshake. If a frame finishes while the buffer
// is still full and not being drained, that frame is dropped and overrun
// pulses for one cycle.
module nibble_parity_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_out_ready,
    output logic [3:0] o_out_data,
    output logic       o_out_valid,
    output logic       o_par_err,
    output logic       o_frm_err,
    output logic       o_overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RECOVER
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_bitIdx;
    logic [3:0]    r_shift;
    logic          r_parBit;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rxS;
    logic          w_bitDone;
    logic          w_halfDone;
    logic          w_complete;

    logic [3:0]    r_outData;
    logic          r_outValid;
    logic          r_parErr;
    logic          r_frmErr;
    logic          r_overrun;

    assign w_rxS      = r_sync2;
    assign w_bitDone  = (r_cnt == CNT_LAST);
    assign w_halfDone = (r_cnt == CNT_HALF);

    // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state logic; w_complete marks the stop-sample edge that finishes a frame
    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxS) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_halfDone) begin
                    w_next = w_rxS ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bitDone && (r_bitIdx == 2'd3)) begin
                    w_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_bitDone) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bitDone) begin
                    w_complete = 1'b1;
                    w_next     = w_rxS ? S_IDLE : S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (w_rxS) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register, bit timer (cleared on state change and at each bit boundary) and data capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitIdx <= 2'd0;
            r_shift  <= 4'd0;
            r_parBit <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || w_bitDone) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                S_START: begin
                    r_bitIdx <= 2'd0;
                end
                S_DATA: begin
                    if (w_bitDone) begin
                        r_shift  <= {w_rxS, r_shift[3:1]};
                        r_bitIdx <= r_bitIdx + 2'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bitDone) begin
                        r_parBit <= w_rxS;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One-entry output buffer: load on frame completion if empty or draining, otherwise flag overrun
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_outData  <= 4'd0;
            r_outValid <= 1'b0;
            r_parErr   <= 1'b0;
            r_frmErr   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_outValid || i_out_ready) begin
                    r_outData  <= r_shift;
                    r_parErr   <= r_parBit ^ (^r_shift);
                    r_frmErr   <= ~w_rxS;
                    r_outValid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_outValid && i_out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign o_out_data  = r_outData;
    assign o_out_valid = r_outValid;
    assign o_par_err   = r_parErr;
    assign o_frm_err   = r_frmErr;
    assign o_overrun   = r_overrun;

endmodule

// File: doc/nibble_parity_rx.md
# nibble_parity_rx

Serial receiver that sits directly upstream of the 4-input XOR parity stage. It deserialises a framed nibble from a single input line: start bit, 4 data bits LSB first, an even-parity bit, then a stop bit. It checks the parity and framing, then holds the nibble and its status in a one-entry output buffer with a valid/ready handshake. The nibble it presents is what the XOR chain consumes.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; even, minimum 4.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line; idles high; asynchronous to clk.
- out_ready  in  1  consumer accepts the buffered nibble.
- out_data  out  4  received nibble; bit 0 is the first data bit received.
- out_valid  out  1  out_data, par_err and frm_err are valid.
- par_err  out  1  parity bit != d0^d1^d2^d3.
- frm_err  out  1  stop bit sampled 0.
- overrun  out  1  one-cycle pulse; a completed frame was dropped because the buffer was full.

## Operation
- rx passes through a 2-flop synchronizer (reset value 1) to give rx_s. All sampling uses rx_s.
- HALF = CLKS_PER_BIT/2. The bit counter cnt is cleared on every state change.
- FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER.
  - IDLE: rx_s==0 moves to START.
  - START: on cnt==HALF-1, sample rx_s. A 0 moves to DATA; a 1 is a glitch and moves to IDLE.
  - DATA: on cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of a 4-bit shift register (LSB-first reception) and increment the bit index. After the 4th bit, move to PARITY.
  - PARITY: on cnt==CLKS_PER_BIT-1, latch the parity bit and move to STOP.
  - STOP: on cnt==CLKS_PER_BIT-1, sample the stop bit and complete the frame. A stop bit of 1 moves to IDLE; a stop bit of 0 moves to RECOVER.
  - RECOVER: wait for rx_s==1, then move to IDLE. This prevents a held-low line (break) from re-triggering.
- Frame completion, on the stop-sample edge:
  - If out_valid==0, or out_valid&&out_ready in the same cycle: load out_data, par_err and frm_err, and set out_valid=1.
  - Otherwise: discard the frame, keep the buffer unchanged, and pulse overrun for 1 cycle.
- A frame with par_err or frm_err is still delivered, with its flags set.
- out_valid&&out_ready with no frame completing clears out_valid. out_data and flags hold their last values.
- Reset values: out_data=0, out_valid=0, par_err=0, frm_err=0, overrun=0, state=IDLE, synchronizer=1.
- rst in any state, including mid-frame, aborts the frame with no output and no overrun. rst wins over every other event in that cycle.

## Timing
- Let E0 be the edge at which IDLE sees rx_s==0. The rx pin falling edge appears in rx_s 2 edges after it is sampled.
- Sample edges, all relative to E0:
  - Start check: E0+HALF.
  - Data bit i (i=0..3): E0+HALF+(i+1)*CLKS_PER_BIT.
  - Parity: E0+HALF+5*CLKS_PER_BIT.
  - Stop: E0+HALF+6*CLKS_PER_BIT.
- out_valid is high in the cycle after the stop-sample edge.
- Handshake:
  - Transfer occurs on an edge where out_valid&&out_ready.
  - out_data and flags stay stable while out_valid&&!out_ready.
  - out_ready may be high while out_valid is low; it has no effect.
- Back-to-back frames are allowed: IDLE can detect a new start bit on the edge after a good stop sample. No buffer bubble is required if the consumer holds out_ready high.

## Test plan
All scenarios use CLKS_PER_BIT=8, with rx driven in whole 8-cycle bit slots.
- Good frame: rx = 0,1,1,0,1,1,1 (data 4'hB, parity 1, stop 1), out_ready=1 -> out_valid pulses 1 cycle with out_data=4'hB, par_err=0, frm_err=0, overrun=0.
- Bad parity: send data 4'h6 with parity 1 -> out_data=4'h6, par_err=1, frm_err=0.
- Glitch, then framing error:
  - rx low for 2 cycles only -> FSM returns to IDLE and out_valid stays 0.
  - Then send data 4'h3, parity 0, stop 0 -> out_data=4'h3, frm_err=1. FSM holds in RECOVER until rx returns high; a following good frame 4'h5 is received correctly.
- Overrun: out_ready=0, send frames 4'hA then 4'h5 -> after the 2nd stop sample, overrun pulses 1 cycle, out_data stays 4'hA, out_valid stays 1. Raising out_ready then transfers 4'hA, and out_valid drops to 0.
- Simultaneous accept and complete: out_valid=1 with 4'h1, out_ready=1 exactly on the stop-sample edge of frame 4'h2 -> 4'h1 is transferred, out_data becomes 4'h2, out_valid stays 1, overrun=0.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 2 -> all outputs are 0 and state is IDLE. The remaining bits of that frame produce no output, and the next full frame 4'hC is received correctly.
